ipdc_win_engine: RTL and testbench

IPDC_WIN_ENGINE -- requirements
Module: ipdc_win_engine

---
 rtl/ipdc_pkg.sv | 24 ++
 rtl/ipdc_img_mem.sv | 24 ++
 rtl/ipdc_win_engine.sv | 156 +++++++++++++++
 tb/tb_ipdc_win_engine.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ipdc_pkg.sv
// Shared definitions for the IPDC window engine: op codes, FSM states, op-code width.
package ipdc_pkg;

  localparam int OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_LOAD     = 4'd0,
    OP_RIGHT    = 4'd1,
    OP_LEFT     = 4'd2,
    OP_UP       = 4'd3,
    OP_DOWN     = 4'd4,
    OP_ZOOM_IN  = 4'd5,
    OP_ZOOM_OUT = 4'd6,
    OP_DISPLAY  = 4'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_UPDATE = 2'd2,
    ST_OUT    = 2'd3
  } state_e;

endpackage

// File: rtl/ipdc_img_mem.sv
// Image store: register array with one synchronous write port and one combinational read port.
module ipdc_img_mem #(
  parameter int AW    = 8,
  parameter int PIX_W = 24
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [PIX_W-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [PIX_W-1:0] o_rdata
);

  localparam int DEPTH = 1 << AW;

  logic [PIX_W-1:0] mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = mem[i_raddr];

endmodule

// File: rtl/ipdc_win_engine.sv
// Window engine: loads a raster image, then pans/zooms a square window and streams its pixels.
module ipdc_win_engine
  import ipdc_pkg::*;
#(
  parameter int IMG_W   = 16,
  parameter int IMG_H   = 16,
  parameter int PIX_W   = 24,
  parameter int WIN_MAX = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_op_valid,
  input  logic [OP_W-1:0]  i_op_mode,
  output logic             o_op_ready,
  input  logic             i_in_valid,
  input  logic [PIX_W-1:0] i_in_data,
  output logic             o_in_ready,
  output logic             o_out_valid,
  output logic [PIX_W-1:0] o_out_data
);

  localparam int XW  = $clog2(IMG_W);
  localparam int YW  = $clog2(IMG_H);
  localparam int AW  = XW + YW;
  localparam int CW  = $clog2(WIN_MAX);
  localparam int WSW = CW + 1;

  state_e          state;
  logic [OP_W-1:0] op_q;
  logic [XW-1:0]   ox, ox_n;
  logic [YW-1:0]   oy, oy_n;
  logic [WSW-1:0]  ws, ws_n, ws_dbl, ws_last;
  logic [CW-1:0]   row, col;
  logic [AW-1:0]   load_addr;
  logic            op_ready;
  logic [XW:0]     x_lim, x_fit;
  logic [YW:0]     y_lim, y_fit;
  logic [YW-1:0]   rd_row;
  logic [XW-1:0]   rd_col;
  logic [PIX_W-1:0] rd_data;

  assign o_op_ready = op_ready;
  assign o_in_ready = (state == ST_LOAD);
  assign ws_dbl     = ws << 1;
  assign ws_last    = ws - WSW'(1);
  assign rd_row     = oy + YW'(row);
  assign rd_col     = ox + XW'(col);

  // Next origin/size; ZOOM_OUT re-clamps the origin against the doubled edge.
  always_comb begin
    ox_n  = ox;
    oy_n  = oy;
    ws_n  = ws;
    x_lim = (XW+1)'(IMG_W) - (XW+1)'(ws);
    y_lim = (YW+1)'(IMG_H) - (YW+1)'(ws);
    x_fit = (XW+1)'(IMG_W) - (XW+1)'(ws_dbl);
    y_fit = (YW+1)'(IMG_H) - (YW+1)'(ws_dbl);
    case (op_q)
      OP_RIGHT: if ({1'b0, ox} < x_lim) ox_n = ox + XW'(1);
      OP_LEFT:  if (ox != '0) ox_n = ox - XW'(1);
      OP_DOWN:  if ({1'b0, oy} < y_lim) oy_n = oy + YW'(1);
      OP_UP:    if (oy != '0) oy_n = oy - YW'(1);
      OP_ZOOM_IN: if (ws > WSW'(WIN_MAX / 4)) ws_n = ws >> 1;
      OP_ZOOM_OUT: begin
        if (ws < WSW'(WIN_MAX)) begin
          ws_n = ws_dbl;
          if ({1'b0, ox} > x_fit) ox_n = x_fit[XW-1:0];
          if ({1'b0, oy} > y_fit) oy_n = y_fit[YW-1:0];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= ST_IDLE;
      op_q      <= '0;
      op_ready  <= 1'b0;
      ox        <= '0;
      oy        <= '0;
      ws        <= WSW'(WIN_MAX);
      row       <= '0;
      col       <= '0;
      load_addr <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          // Ready is re-armed one cycle after every op (and after reset).
          if (!op_ready) begin
            op_ready <= 1'b1;
          end else if (i_op_valid) begin
            op_ready <= 1'b0;
            op_q     <= i_op_mode;
            if (i_op_mode == OP_LOAD) begin
              load_addr <= '0;
              state     <= ST_LOAD;
            end else if (i_op_mode <= OP_DISPLAY) begin
              state <= ST_UPDATE;
            end
          end
        end
        ST_LOAD: begin
          if (i_in_valid) begin
            load_addr <= load_addr + AW'(1);
            if (&load_addr) state <= ST_IDLE;
          end
        end
        ST_UPDATE: begin
          ox    <= ox_n;
          oy    <= oy_n;
          ws    <= ws_n;
          row   <= '0;
          col   <= '0;
          state <= ST_OUT;
        end
        ST_OUT: begin
          if ({1'b0, col} == ws_last) begin
            col <= '0;
            if ({1'b0, row} == ws_last) state <= ST_IDLE;
            else row <= row + CW'(1);
          end else begin
            col <= col + CW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_out_valid <= 1'b0;
      o_out_data  <= '0;
    end else if (state == ST_OUT) begin
      o_out_valid <= 1'b1;
      o_out_data  <= rd_data;
    end else begin
      o_out_valid <= 1'b0;
      o_out_data  <= '0;
    end
  end

  ipdc_img_mem #(
    .AW    (AW),
    .PIX_W (PIX_W)
  ) u_img_mem (
    .i_clk   (i_clk),
    .i_we    ((state == ST_LOAD) && i_in_valid),
    .i_waddr (load_addr),
    .i_wdata (i_in_data),
    .i_raddr ({rd_row, rd_col}),
    .o_rdata (rd_data)
  );

endmodule

// File: tb/tb_ipdc_win_engine.sv
// Directed self-checking bench for ipdc_win_engine at default parameters, image pixel(r,c)=16r+c.
module tb_ipdc_win_engine;
  import ipdc_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_op_valid = 1'b0;
  logic [3:0]  i_op_mode = '0;
  logic        o_op_ready;
  logic        i_in_valid = 1'b0;
  logic [23:0] i_in_data = '0;
  logic        o_in_ready;
  logic        o_out_valid;
  logic [23:0] o_out_data;

  int vectors = 0;
  int miscompares = 0;

  logic [23:0] beats[$];
  logic [23:0] first_beat;
  int first_lat, done_lat, zero_bad;
  logic ready_after_accept;

  always #5 i_clk = ~i_clk;

  ipdc_win_engine #(
    .IMG_W   (16),
    .IMG_H   (16),
    .PIX_W   (24),
    .WIN_MAX (4)
  ) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_op_valid  (i_op_valid),
    .i_op_mode   (i_op_mode),
    .o_op_ready  (o_op_ready),
    .i_in_valid  (i_in_valid),
    .i_in_data   (i_in_data),
    .o_in_ready  (o_in_ready),
    .o_out_valid (o_out_valid),
    .o_out_data  (o_out_data)
  );

  function automatic logic [23:0] exp_beat(input int ox, input int oy, input int ws, input int i);
    return 24'(16 * (oy + i / ws) + ox + i % ws);
  endfunction

  task automatic wait_ready();
    int t = 0;
    while (!o_op_ready && t < 50) begin
      @(posedge i_clk); #1; t++;
    end
    if (!o_op_ready) begin
      vectors++; miscompares++;
      $display("FAIL ready_timeout: op_ready=%0b required 1", o_op_ready);
    end
  endtask

  // Issue one op and collect its output beats until op_ready returns.
  task automatic do_op(input logic [3:0] mode, input bit noise);
    beats.delete();
    first_lat = -1; done_lat = -1; zero_bad = 0;
    wait_ready();
    i_op_valid = 1'b1; i_op_mode = mode;
    @(posedge i_clk); #1;
    ready_after_accept = o_op_ready;
    i_op_valid = noise; i_op_mode = 4'(OP_RIGHT);
    for (int k = 1; k <= 100; k++) begin
      @(posedge i_clk); #1;
      if (o_out_valid) begin
        if (first_lat < 0) first_lat = k;
        beats.push_back(o_out_data);
      end else if (o_out_data !== '0) begin
        zero_bad++;
      end
      if (o_op_ready) begin
        done_lat = k;
        i_op_valid = 1'b0;
        break;
      end
    end
    i_op_valid = 1'b0;
    if (done_lat < 0) begin
      vectors++; miscompares++;
      $display("FAIL op_timeout: mode=%0d never returned op_ready", mode);
    end
    first_beat = (beats.size() > 0) ? beats[0] : 24'hxxxxxx;
  endtask

  task automatic do_load(input bit toggle);
    wait_ready();
    i_op_valid = 1'b1; i_op_mode = 4'(OP_LOAD);
    @(posedge i_clk); #1;
    i_op_valid = 1'b0;
    vectors++;
    if (o_in_ready !== 1'b1) begin
      miscompares++; $display("FAIL load_in_ready: got %0b required 1", o_in_ready);
    end
    for (int p = 0; p < 256; p++) begin
      if (toggle) begin
        i_in_valid = 1'b0; i_in_data = 24'hFFFFFF;
        @(posedge i_clk); #1;
      end
      i_in_valid = 1'b1; i_in_data = 24'(p);
      @(posedge i_clk); #1;
    end
    i_in_valid = 1'b0; i_in_data = '0;
    vectors++;
    if (o_in_ready !== 1'b0 || o_op_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL load_end: in_ready=%0b op_ready=%0b required 0 0", o_in_ready, o_op_ready);
    end
    @(posedge i_clk); #1;
    vectors++;
    if (o_op_ready !== 1'b1) begin
      miscompares++; $display("FAIL load_ready_return: got %0b required 1", o_op_ready);
    end
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    vectors++;
    if (o_op_ready !== 1'b0 || o_in_ready !== 1'b0 || o_out_valid !== 1'b0 || o_out_data !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: op_ready=%0b in_ready=%0b out_valid=%0b out_data=%0h required 0 0 0 0",
               o_op_ready, o_in_ready, o_out_valid, o_out_data);
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    vectors++;
    if (o_op_ready !== 1'b1) begin
      miscompares++; $display("FAIL reset_release_ready: got %0b required 1", o_op_ready);
    end
  endtask

  task automatic test_display_reset_window();
    do_op(4'(OP_DISPLAY), 1'b0);
    vectors++;
    if (ready_after_accept !== 1'b0) begin
      miscompares++; $display("FAIL display_busy: op_ready=%0b required 0", ready_after_accept);
    end
    vectors++;
    if (first_lat != 2 || done_lat != 18) begin
      miscompares++; $display("FAIL display_timing: first=%0d done=%0d required 2 18", first_lat, done_lat);
    end
    vectors++;
    if (beats.size() != 16 || zero_bad != 0) begin
      miscompares++; $display("FAIL display_count: beats=%0d zero_bad=%0d required 16 0", beats.size(), zero_bad);
    end
    for (int i = 0; i < beats.size(); i++) begin
      vectors++;
      if (beats[i] !== exp_beat(0, 0, 4, i)) begin
        miscompares++; $display("FAIL display_beat%0d: got %0h required %0h", i, beats[i], exp_beat(0, 0, 4, i));
      end
    end
  endtask

  task automatic test_reserved();
    do_op(4'd11, 1'b0);
    vectors++;
    if (beats.size() != 0 || done_lat != 1) begin
      miscompares++; $display("FAIL reserved_op: beats=%0d done=%0d required 0 1", beats.size(), done_lat);
    end
    do_op(4'(OP_DISPLAY), 1'b0);
    vectors++;
    if (first_beat !== 24'h00 || beats.size() != 16) begin
      miscompares++; $display("FAIL reserved_nochange: first=%0h beats=%0d required 0 16", first_beat, beats.size());
    end
  endtask

  task automatic test_ignored_inputs();
    i_in_valid = 1'b1; i_in_data = 24'h123456;
    repeat (3) @(posedge i_clk);
    #1;
    i_in_valid = 1'b0; i_in_data = '0;
    do_op(4'(OP_DISPLAY), 1'b1);
    do_op(4'(OP_DISPLAY), 1'b0);
    vectors++;
    if (beats.size() != 16) begin
      miscompares++; $display("FAIL ignore_count: beats=%0d required 16", beats.size());
    end
    for (int i = 0; i < beats.size(); i++) begin
      vectors++;
      if (beats[i] !== exp_beat(0, 0, 4, i)) begin
        miscompares++; $display("FAIL ignore_beat%0d: got %0h required %0h", i, beats[i], exp_beat(0, 0, 4, i));
      end
    end
  endtask

  task automatic test_right_down_sat();
    for (int k = 1; k <= 13; k++) begin
      do_op(4'(OP_RIGHT), 1'b0);
      vectors++;
      if (beats.size() != 16 || first_beat !== exp_beat((k > 12) ? 12 : k, 0, 4, 0)) begin
        miscompares++;
        $display("FAIL right%0d: beats=%0d first=%0h required 16 %0h", k, beats.size(), first_beat,
                 exp_beat((k > 12) ? 12 : k, 0, 4, 0));
      end
    end
    for (int k = 1; k <= 13; k++) begin
      do_op(4'(OP_DOWN), 1'b0);
      vectors++;
      if (beats.size() != 16 || first_beat !== exp_beat(12, (k > 12) ? 12 : k, 4, 0)) begin
        miscompares++;
        $display("FAIL down%0d: beats=%0d first=%0h required 16 %0h", k, beats.size(), first_beat,
                 exp_beat(12, (k > 12) ? 12 : k, 4, 0));
      end
    end
  endtask

  task automatic test_zoom_clamp();
    do_op(4'(OP_ZOOM_IN), 1'b0);
    vectors++;
    if (beats.size() != 4 || first_beat !== 24'hCC || beats[3] !== 24'hDD) begin
      miscompares++; $display("FAIL clamp_zin: beats=%0d first=%0h required 4 cc", beats.size(), first_beat);
    end
    do_op(4'(OP_RIGHT), 1'b0);
    vectors++;
    if (first_beat !== 24'hCD) begin
      miscompares++; $display("FAIL clamp_right1: first=%0h required cd", first_beat);
    end
    do_op(4'(OP_RIGHT), 1'b0);
    do_op(4'(OP_RIGHT), 1'b0);
    vectors++;
    if (first_beat !== 24'hCE || beats.size() != 4) begin
      miscompares++; $display("FAIL clamp_right_sat: first=%0h beats=%0d required ce 4", first_beat, beats.size());
    end
    do_op(4'(OP_ZOOM_OUT), 1'b0);
    vectors++;
    if (beats.size() != 16) begin
      miscompares++; $display("FAIL clamp_zout_count: beats=%0d required 16", beats.size());
    end
    for (int i = 0; i < beats.size(); i++) begin
      vectors++;
      if (beats[i] !== exp_beat(12, 12, 4, i)) begin
        miscompares++; $display("FAIL clamp_zout_beat%0d: got %0h required %0h", i, beats[i], exp_beat(12, 12, 4, i));
      end
    end
    do_op(4'(OP_UP), 1'b0);
    vectors++;
    if (first_beat !== 24'hBC) begin
      miscompares++; $display("FAIL up: first=%0h required bc", first_beat);
    end
    do_op(4'(OP_LEFT), 1'b0);
    vectors++;
    if (first_beat !== 24'hBB) begin
      miscompares++; $display("FAIL left: first=%0h required bb", first_beat);
    end
  endtask

  task automatic test_zoom_sat();
    int exp_n [6] = '{4, 1, 1, 4, 16, 16};
    logic [3:0] modes [6];
    modes = '{4'(OP_ZOOM_IN), 4'(OP_ZOOM_IN), 4'(OP_ZOOM_IN), 4'(OP_ZOOM_OUT), 4'(OP_ZOOM_OUT), 4'(OP_ZOOM_OUT)};
    for (int k = 0; k < 6; k++) begin
      do_op(modes[k], 1'b0);
      vectors++;
      if (beats.size() != exp_n[k] || first_beat !== 24'hBB) begin
        miscompares++;
        $display("FAIL zoom_step%0d: beats=%0d first=%0h required %0d bb", k, beats.size(), first_beat, exp_n[k]);
      end
    end
  endtask

  task automatic test_reset_mid_out();
    do_op(4'(OP_RIGHT), 1'b0);
    wait_ready();
    i_op_valid = 1'b1; i_op_mode = 4'(OP_DISPLAY);
    @(posedge i_clk); #1;
    i_op_valid = 1'b0;
    repeat (5) @(posedge i_clk);
    #1;
    vectors++;
    if (o_out_valid !== 1'b1) begin
      miscompares++; $display("FAIL midout_active: out_valid=%0b required 1", o_out_valid);
    end
    #2 i_rst_n = 1'b0;
    #1;
    vectors++;
    if (o_out_valid !== 1'b0 || o_out_data !== '0 || o_op_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL midout_reset: out_valid=%0b out_data=%0h op_ready=%0b required 0 0 0",
               o_out_valid, o_out_data, o_op_ready);
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    vectors++;
    if (o_op_ready !== 1'b1 || o_out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL midout_release: op_ready=%0b out_valid=%0b required 1 0", o_op_ready, o_out_valid);
    end
    do_op(4'(OP_DISPLAY), 1'b0);
    vectors++;
    if (beats.size() != 16) begin
      miscompares++; $display("FAIL midout_display_count: beats=%0d required 16", beats.size());
    end
    for (int i = 0; i < beats.size(); i++) begin
      vectors++;
      if (beats[i] !== exp_beat(0, 0, 4, i)) begin
        miscompares++; $display("FAIL midout_beat%0d: got %0h required %0h", i, beats[i], exp_beat(0, 0, 4, i));
      end
    end
  endtask

  task automatic test_load_toggle();
    do_load(1'b1);
    do_op(4'(OP_DISPLAY), 1'b0);
    vectors++;
    if (beats.size() != 16) begin
      miscompares++; $display("FAIL toggle_count: beats=%0d required 16", beats.size());
    end
    for (int i = 0; i < beats.size(); i++) begin
      vectors++;
      if (beats[i] !== exp_beat(0, 0, 4, i)) begin
        miscompares++; $display("FAIL toggle_beat%0d: got %0h required %0h", i, beats[i], exp_beat(0, 0, 4, i));
      end
    end
    for (int k = 0; k < 12; k++) do_op(4'(OP_DOWN), 1'b0);
    do_op(4'(OP_DISPLAY), 1'b0);
    vectors++;
    if (beats.size() != 16 || beats[15] !== 24'hF3) begin
      miscompares++; $display("FAIL toggle_bottom: beats=%0d last=%0h required 16 f3", beats.size(),
                              (beats.size() == 16) ? beats[15] : 24'hxxxxxx);
    end
  endtask

  initial begin
    test_reset();
    do_load(1'b0);
    test_display_reset_window();
    test_reserved();
    test_ignored_inputs();
    test_right_down_sat();
    test_zoom_clamp();
    test_zoom_sat();
    test_reset_mid_out();
    test_load_toggle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time budget");
    $fatal(1);
  end

endmodule
